gl2_stream_fork_n: RTL
======================

// Module: gl2_stream_fork_n
// PURPOSE
//  N-way broadcast fork for the video stream (data + tlast/tuser), successor to the fixed 4-way fork.
//  One-entry holding register plus per-branch "delivered" flags, so each branch accepts the beat on its own cycle.
//  Upstream sees one beat per cycle when all branches are ready.
//  up_valid never reaches down_valid combinationally, and down_valid never depends on down_ready (AXI-compliant).
//  Sits between the pixel source and the parallel downscaler/line-buffer branches.
// PARAMETERS
//  D_WIDTH  8  data width per beat
//  N_OUT    4  number of downstream branches (2..16)
// PORTS
//  clk           in   1              single clock, all logic rising-edge
//  rst           in   1              synchronous, active-high reset
//  up_data       in   D_WIDTH        upstream data
//  up_valid      in   1              upstream valid
//  up_tlast      in   1              end-of-line marker
//  up_tuser      in   1              start-of-frame marker
//  up_ready      out  1              upstream ready
//  down_data     out  N_OUT*D_WIDTH  branch i data at bits [i*D_WIDTH +: D_WIDTH], all equal
//  down_valid    out  N_OUT          per-branch valid
//  down_tlast    out  N_OUT          per-branch tlast copy
//  down_tuser    out  N_OUT          per-branch tuser copy
//  down_ready    in   N_OUT          per-branch ready
//  branch_en     in   N_OUT          (only with GL2_FORK_MASK_EN) branch enable request
// BEHAVIOUR
//  State:
//   - full: holding register occupied
//   - hold_data / hold_tlast / hold_tuser: stored beat
//   - done[N_OUT-1:0]: branch already took the held beat
//   - act[N_OUT-1:0]: active mask, all ones without the macro
//  Reset (rst=1 at posedge): full=0, done=0, act=all ones, hold_* = 0.
//   - Outputs during/after reset: down_valid=0, down_data=0, down_tlast=0, down_tuser=0, up_ready=1.
//   - Reset mid-beat discards the held beat; partially delivered branches are not completed.
//  Output decode:
//   - down_valid[i] = full & act[i] & ~done[i]
//   - down_data/tlast/tuser = hold_* on every branch
//   - hs[i] = down_valid[i] & down_ready[i]
//   - fin = full & &(done | hs | ~act)   (held beat fully delivered this cycle)
//   - up_ready = ~full | fin   (combinational from down_ready; no path from up_valid)
//  FSM, two states:
//   - EMPTY (full=0):
//     - up_valid -> load hold_*, done=0 -> FULL
//   - FULL (full=1):
//     - ~fin -> done |= hs; hold_* stable; stay FULL
//     - fin & up_valid -> load new beat, done=0; stay FULL (back-to-back, 1 beat/clk)
//     - fin & ~up_valid -> done=0 -> EMPTY
//  Latency: beat accepted at edge k is visible on down_* in cycle k+1; minimum 1 clk, no bubble under full ready.
//  Branches skew arbitrarily. A stalled branch holds the whole fork; branches that are done show valid=0.
//  Simultaneous last hs and new up beat: new beat loads, all done bits clear on the same edge.
//  Masked branch (act[i]=0): valid=0, counts as done; its down_ready is ignored.
//  All act=0: fin=1 whenever full, so beats are consumed and dropped at 1 beat/clk.
// CONFIGURATION
//  GL2_FORK_MASK_EN defined:
//   - branch_en port exists.
//   - act <= branch_en on each accepted upstream beat with up_tuser=1, applied to that beat onward.
//   - act is frame-aligned; branch_en changes mid-frame are ignored until the next SOF.
//  GL2_FORK_MASK_EN undefined:
//   - no branch_en port; act tied to all ones.
//   - plain lossless N-way broadcast.
// TESTING
//  T1:
//   - stimulus: reset, then N_OUT=4 all ready, stream 0x10..0x1F with tlast on 0x1F
//   - response: each branch gets 16 beats in order, up_ready=1 throughout, first down_valid 1 clk after first accept
//  T2:
//   - stimulus: hold 0xA5; ready_a=1 in cycle 1, ready_b in cycle 3, ready_c/ready_d in cycle 5
//   - response: valid_a drops after cycle 1, valid_b after cycle 3; up_ready=1 only in cycle 5; data stays 0xA5
//  T3:
//   - stimulus: random per-branch ready at 30% duty, 1000 beats
//   - response: every branch receives an identical sequence, no duplicate or lost beat, down_* stable while valid & ~ready
//  T4:
//   - stimulus: assert rst while full with done=0101
//   - response: next cycle all down_valid=0, up_ready=1; the following beat is delivered to all 4 branches
//  T5 (GL2_FORK_MASK_EN):
//   - stimulus: branch_en=0011 on SOF beat; ready_c=ready_d=0
//   - response: branches a,b get the whole frame; c,d valid=0; no stall
//  T6 (GL2_FORK_MASK_EN):
//   - stimulus: branch_en=0000 at SOF, 8 beats
//   - response: all beats consumed at 1 beat/clk, down_valid=0; next SOF with 1111 restores all branches

Source files
------------

// File: rtl/gl2_stream_fork_n_if.sv
// ---------------------------------------------------------------------------
// gl2_stream_fork_n_if
//   Stream bundle for the N-way video broadcast fork: one upstream beat
//   channel (data + tlast/tuser) and N_OUT downstream copies of it.
//
//   Optional feature macro: GL2_FORK_MASK_EN (adds branch_en).
//
//   Signals
//     up_data    [D_WIDTH]        upstream data
//     up_valid / up_ready         upstream handshake
//     up_tlast / up_tuser         end-of-line / start-of-frame markers
//     down_data  [N_OUT*D_WIDTH]  branch i at [i*D_WIDTH +: D_WIDTH]
//     down_valid / down_ready     per-branch handshake
//     down_tlast / down_tuser     per-branch marker copies
//     branch_en  [N_OUT]          branch enable request (mask build only)
//
//   Modports
//     slave  : the fork itself (consumes up_*, produces down_*)
//     master : the environment around the fork (source + branch sinks)
// ---------------------------------------------------------------------------
interface gl2_stream_fork_n_if #(
  parameter int D_WIDTH = 8,
  parameter int N_OUT   = 4
);
  logic [D_WIDTH-1:0]       up_data;
  logic                     up_valid;
  logic                     up_tlast;
  logic                     up_tuser;
  logic                     up_ready;
  logic [N_OUT*D_WIDTH-1:0] down_data;
  logic [N_OUT-1:0]         down_valid;
  logic [N_OUT-1:0]         down_tlast;
  logic [N_OUT-1:0]         down_tuser;
  logic [N_OUT-1:0]         down_ready;
`ifdef GL2_FORK_MASK_EN
  logic [N_OUT-1:0]         branch_en;

  modport slave (
    input  up_data, up_valid, up_tlast, up_tuser, down_ready, branch_en,
    output up_ready, down_data, down_valid, down_tlast, down_tuser
  );
  modport master (
    output up_data, up_valid, up_tlast, up_tuser, down_ready, branch_en,
    input  up_ready, down_data, down_valid, down_tlast, down_tuser
  );
`else
  modport slave (
    input  up_data, up_valid, up_tlast, up_tuser, down_ready,
    output up_ready, down_data, down_valid, down_tlast, down_tuser
  );
  modport master (
    output up_data, up_valid, up_tlast, up_tuser, down_ready,
    input  up_ready, down_data, down_valid, down_tlast, down_tuser
  );
`endif
endinterface

// File: rtl/gl2_stream_fork_n.sv
// ---------------------------------------------------------------------------
// gl2_stream_fork_n
//   N-way broadcast fork for the video stream. A single holding register
//   keeps the current beat; a per-branch "done" flag records which branches
//   already took it, so every branch can accept on its own cycle. The next
//   upstream beat is taken on the same edge the held beat finishes, giving
//   one beat per clock when all branches are ready.
//   down_valid comes from registers only (no up_valid -> down_valid path and
//   no dependence on down_ready).
//
//   Optional feature macro: GL2_FORK_MASK_EN
//     defined   : branch_en selects the active branches; sampled on every
//                 accepted start-of-frame beat (up_tuser=1) and applied from
//                 that beat onward. Inactive branches see valid=0 and never
//                 stall the fork.
//     undefined : every branch is always active (lossless broadcast).
//
//   Ports
//     clk      in  rising-edge clock
//     rst      in  synchronous active-high reset
//     io_strm  --  gl2_stream_fork_n_if.slave (up_* in, down_* out)
// ---------------------------------------------------------------------------
module gl2_stream_fork_n #(
  parameter int D_WIDTH = 8,
  parameter int N_OUT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  gl2_stream_fork_n_if.slave    io_strm
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [D_WIDTH-1:0] r_hold_data;
  logic               r_hold_tlast;
  logic               r_hold_tuser;
  logic [N_OUT-1:0]   r_done;
  logic [N_OUT-1:0]   w_done_nxt;
  logic [N_OUT-1:0]   w_act;
  logic [N_OUT-1:0]   w_valid;
  logic [N_OUT-1:0]   w_hs;
  logic               w_full;
  logic               w_fin;
  logic               w_up_ready;
  logic               w_load;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  assign w_full  = (r_state == ST_FULL);
  assign w_valid = {N_OUT{w_full}} & w_act & ~r_done;
  assign w_hs    = w_valid & io_strm.down_ready;

  // Held beat is finished once every active branch has either taken it
  // earlier or is taking it right now; masked branches count as done.
  assign w_fin      = w_full & (&(r_done | w_hs | ~w_act));
  assign w_up_ready = ~w_full | w_fin;
  assign w_load     = io_strm.up_valid & w_up_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    case (r_state)
      ST_EMPTY: begin
        if (io_strm.up_valid) begin
          w_state_nxt = ST_FULL;
          w_done_nxt  = '0;
        end
      end
      ST_FULL: begin
        if (!w_fin) begin
          w_done_nxt = r_done | w_hs;
        end else begin
          // Last delivery and a new beat on the same edge: reload and
          // clear all done flags together, no bubble.
          w_done_nxt  = '0;
          w_state_nxt = io_strm.up_valid ? ST_FULL : ST_EMPTY;
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and holding register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_done       <= '0;
      // NOTE: the holding register is reset (not just qualified by valid)
      // because down_data/tlast/tuser must read zero straight after reset.
      r_hold_data  <= '0;
      r_hold_tlast <= 1'b0;
      r_hold_tuser <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_hold_data  <= io_strm.up_data;
        r_hold_tlast <= io_strm.up_tlast;
        r_hold_tuser <= io_strm.up_tuser;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Active branch mask
  // -------------------------------------------------------------------------
`ifdef GL2_FORK_MASK_EN
  logic [N_OUT-1:0] r_act;

  // Frame-aligned: only a start-of-frame beat re-samples branch_en, and the
  // new mask governs that very beat because it loads on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act <= '1;
    end else if (w_load && io_strm.up_tuser) begin
      r_act <= io_strm.branch_en;
    end
  end

  assign w_act = r_act;
`else
  assign w_act = '1;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign io_strm.up_ready   = w_up_ready;
  assign io_strm.down_valid = w_valid;
  assign io_strm.down_data  = {N_OUT{r_hold_data}};
  assign io_strm.down_tlast = {N_OUT{r_hold_tlast}};
  assign io_strm.down_tuser = {N_OUT{r_hold_tuser}};

endmodule
